dbu_ctrl: RTL and testbench

DBU_CTRL -- requirements
Module: dbu_ctrl

---
 rtl/dbu_pkg.sv | 42 ++++
 rtl/btn_filter.sv | 60 ++++++
 rtl/dbu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dbu_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbu_pkg.sv
// -----------------------------------------------------------------------------
// dbu_pkg
// Shared definitions for the debug unit controller: run-control FSM state
// encoding, display select codes, data-path widths and the bit positions of
// the packed CPU control snapshot shown on the LEDs.
// -----------------------------------------------------------------------------
package dbu_pkg;

   // Run-control FSM states
   typedef enum logic [1:0] {
      HALT     = 2'd0,
      RUN      = 2'd1,
      STEP     = 2'd2,
      WAIT_REL = 2'd3
   } state_e;

   // Display select codes (sel input)
   localparam logic [2:0] SEL_MRF    = 3'd0;  // memory or register-file word
   localparam logic [2:0] SEL_PC     = 3'd1;
   localparam logic [2:0] SEL_NPC    = 3'd2;
   localparam logic [2:0] SEL_IR     = 3'd3;
   localparam logic [2:0] SEL_ID_EX  = 3'd4;
   localparam logic [2:0] SEL_EX_MEM = 3'd5;
   localparam logic [2:0] SEL_MEM_WB = 3'd6;
   localparam logic [2:0] SEL_ADDR   = 3'd7;  // current debug address

   // Data-path widths
   localparam int TAP_W  = 32;
   localparam int DISP_W = 32;
   localparam int LED_W  = 16;
   localparam int CTRL_W = 16;

   // Bit positions inside the packed ctrl snapshot
   localparam int CTRL_REG_WRITE = 0;
   localparam int CTRL_MEM_READ  = 1;
   localparam int CTRL_MEM_WRITE = 2;
   localparam int CTRL_BRANCH    = 3;
   localparam int CTRL_JUMP      = 4;
   localparam int CTRL_ALU_SRC   = 5;
   localparam int CTRL_ALU_OP    = 8;  // LSB of a 4-bit ALU operation field

endpackage

// File: rtl/btn_filter.sv
// -----------------------------------------------------------------------------
// btn_filter
// Conditions one raw push-button: 2-flop synchronizer, debounce counter and
// rising-edge detector.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   raw    in   raw button level, asynchronous to clk
//   level  out  debounced level; follows the synchronized input only after
//               DB_CNT consecutive samples that differ from the current level
//   pulse  out  one-cycle pulse on each 0->1 transition of level
// -----------------------------------------------------------------------------
module btn_filter #(
   parameter int DB_CNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

   logic             sync_a;
   logic             sync_b;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values present before the clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a  <= 1'b0;
         sync_b  <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_a  <= raw;
         sync_b  <= sync_a;
         level_q <= level;
         // Any sample equal to the current level restarts the stability run.
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DB_CNT - 1)) begin
            level <= sync_b;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // level_q clears on reset, so a button held through reset produces a
   // fresh press once it has been debounced again.
   assign pulse = level & ~level_q;

endmodule

// File: rtl/dbu_ctrl.sv
// -----------------------------------------------------------------------------
// dbu_ctrl
// Debug unit controller for a pipelined CPU: run/single-step control via a
// clock-enable, a button-driven debug address, and registered display/LED
// multiplexers over the CPU debug taps.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   succ       in   1 = continuous run, 0 = single-step mode
//   step       in   raw single-step button
//   inc, dec   in   raw debug-address increment / decrement buttons
//   sel        in   display select code (SEL_* in dbu_pkg)
//   m_rf       in   1 = show data memory word, 0 = show register-file word
//   pc .. mem_wb, m_data, rf_data   in   32-bit CPU debug taps
//   ctrl       in   packed CPU control snapshot
//   cpu_en     out  CPU clock-enable
//   m_rf_addr  out  debug read address into CPU memory / register file
//   disp       out  registered display word
//   led        out  registered LED word
// -----------------------------------------------------------------------------
module dbu_ctrl
   import dbu_pkg::*;
#(
   parameter int DB_CNT = 4,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              succ,
   input  logic              step,
   input  logic              inc,
   input  logic              dec,
   input  logic [2:0]        sel,
   input  logic              m_rf,
   input  logic [TAP_W-1:0]  pc,
   input  logic [TAP_W-1:0]  npc,
   input  logic [TAP_W-1:0]  ir,
   input  logic [TAP_W-1:0]  id_ex,
   input  logic [TAP_W-1:0]  ex_mem,
   input  logic [TAP_W-1:0]  mem_wb,
   input  logic [TAP_W-1:0]  m_data,
   input  logic [TAP_W-1:0]  rf_data,
   input  logic [CTRL_W-1:0] ctrl,
   output logic              cpu_en,
   output logic [ADDR_W-1:0] m_rf_addr,
   output logic [DISP_W-1:0] disp,
   output logic [LED_W-1:0]  led
);

   // ---------------------------------------------------------------------------
   // Button conditioning
   // ---------------------------------------------------------------------------
   logic step_level, step_pulse;
   logic inc_level, inc_pulse;
   logic dec_level, dec_pulse;

   btn_filter #(.DB_CNT(DB_CNT)) u_step_filter (
      .clk   (clk),
      .rst   (rst),
      .raw   (step),
      .level (step_level),
      .pulse (step_pulse)
   );

   btn_filter #(.DB_CNT(DB_CNT)) u_inc_filter (
      .clk   (clk),
      .rst   (rst),
      .raw   (inc),
      .level (inc_level),
      .pulse (inc_pulse)
   );

   btn_filter #(.DB_CNT(DB_CNT)) u_dec_filter (
      .clk   (clk),
      .rst   (rst),
      .raw   (dec),
      .level (dec_level),
      .pulse (dec_pulse)
   );

   // The address buttons act on their press pulses only.
   logic unused_levels;
   assign unused_levels = inc_level ^ dec_level;

   // ---------------------------------------------------------------------------
   // Run-control FSM
   // ---------------------------------------------------------------------------
   state_e state, state_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= HALT;
      else      state <= state_nx;
   end

   // cpu_en decodes the state register alone, so reset removes it at once
   // without waiting for a clock edge.
   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      cpu_en   = 1'b0;
      unique case (state)
         HALT: begin
            if (succ)            state_nx = RUN;
            else if (step_pulse) state_nx = STEP;
         end
         RUN: begin
            cpu_en = 1'b1;
            if (!succ) state_nx = HALT;
         end
         STEP: begin
            // Exactly one enabled cycle per accepted press.
            cpu_en   = 1'b1;
            state_nx = WAIT_REL;
         end
         WAIT_REL: begin
            // A held button must be released before another step is taken.
            if (succ)             state_nx = RUN;
            else if (!step_level) state_nx = HALT;
         end
         default: state_nx = HALT;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Debug address: wraps modulo 2^ADDR_W; simultaneous presses cancel.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_rf_addr <= '0;
      end else if (inc_pulse && !dec_pulse) begin
         m_rf_addr <= m_rf_addr + 1'b1;
      end else if (dec_pulse && !inc_pulse) begin
         m_rf_addr <= m_rf_addr - 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Display and LED multiplexers, registered every cycle in every state
   // ---------------------------------------------------------------------------
   logic [DISP_W-1:0] disp_d;
   logic [LED_W-1:0]  led_d;

   always_comb begin
      disp_d = '0;
      unique case (sel)
         SEL_MRF:    disp_d = m_rf ? m_data : rf_data;
         SEL_PC:     disp_d = pc;
         SEL_NPC:    disp_d = npc;
         SEL_IR:     disp_d = ir;
         SEL_ID_EX:  disp_d = id_ex;
         SEL_EX_MEM: disp_d = ex_mem;
         SEL_MEM_WB: disp_d = mem_wb;
         SEL_ADDR:   disp_d = DISP_W'(m_rf_addr);
         default:    disp_d = '0;
      endcase
   end

   assign led_d = (sel == SEL_MRF) ? LED_W'(m_rf_addr) : ctrl;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp <= '0;
         led  <= '0;
      end else begin
         disp <= disp_d;
         led  <= led_d;
      end
   end

endmodule

// File: tb/tb_dbu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dbu_ctrl
// Self-checking bench for dbu_ctrl. Stimulus pushes expected responses into
// scoreboard queues; a monitor on the falling clock edge pops and compares
// them whenever the DUT presents an enable cycle or a scheduled output.
// -----------------------------------------------------------------------------
module tb_dbu_ctrl;
   import dbu_pkg::*;

   localparam int DB  = 4;
   localparam int AW  = 8;
   localparam int LAT = 2 + DB + 1;  // raw press -> cpu_en / address update

   logic              clk;
   logic              rst;
   logic              succ, step, inc, dec;
   logic [2:0]        sel;
   logic              m_rf;
   logic [31:0]       pc, npc, ir, id_ex, ex_mem, mem_wb, m_data, rf_data;
   logic [CTRL_W-1:0] ctrl;
   logic              cpu_en;
   logic [AW-1:0]     m_rf_addr;
   logic [31:0]       disp;
   logic [15:0]       led;

   dbu_ctrl #(.DB_CNT(DB), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .succ      (succ),
      .step      (step),
      .inc       (inc),
      .dec       (dec),
      .sel       (sel),
      .m_rf      (m_rf),
      .pc        (pc),
      .npc       (npc),
      .ir        (ir),
      .id_ex     (id_ex),
      .ex_mem    (ex_mem),
      .mem_wb    (mem_wb),
      .m_data    (m_data),
      .rf_data   (rf_data),
      .ctrl      (ctrl),
      .cpu_en    (cpu_en),
      .m_rf_addr (m_rf_addr),
      .disp      (disp),
      .led       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef enum {OBS_DISP, OBS_LED, OBS_ADDR} obs_e;
   typedef struct {
      string       name;
      int          cyc_at;
      obs_e        sig;
      logic [31:0] val;
   } exp_t;

   exp_t obs_q[$];
   int   en_q[$];

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      else
         pass_cnt++;
   endtask

   task automatic expect_obs(input string name, input int at, input obs_e sig,
                             input logic [31:0] val);
      exp_t item;
      item.name   = name;
      item.cyc_at = at;
      item.sig    = sig;
      item.val    = val;
      obs_q.push_back(item);
   endtask

   logic [31:0] obs_act;

   always @(negedge clk) begin
      if (cpu_en === 1'b1) begin
         if (en_q.size() == 0) begin
            total_cnt++;
            $display("FAIL cpu_en_spurious: cpu_en=1 at cycle %0d, none expected", cyc);
         end else begin
            check("cpu_en_cycle", 32'(cyc), 32'(en_q.pop_front()));
         end
      end
      for (int i = obs_q.size() - 1; i >= 0; i--) begin
         if (obs_q[i].cyc_at == cyc) begin
            case (obs_q[i].sig)
               OBS_DISP: obs_act = disp;
               OBS_LED:  obs_act = 32'(led);
               default:  obs_act = 32'(m_rf_addr);
            endcase
            check(obs_q[i].name, obs_act, obs_q[i].val);
            obs_q.delete(i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_inc();
      inc = 1'b1;
      tick(10);
      inc = 1'b0;
      tick(10);
   endtask

   logic [2:0]  sel_tab  [8];
   logic [31:0] disp_tab [8];
   logic [15:0] led_tab  [8];

   initial begin
      int e;
      int f;

      rst  = 1'b0;
      succ = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0;
      sel  = SEL_MRF;
      m_rf = 1'b1;
      pc      = 32'h0040_0010;
      npc     = 32'h0040_0014;
      ir      = 32'h8C22_0004;
      id_ex   = 32'h1111_0001;
      ex_mem  = 32'h2222_0002;
      mem_wb  = 32'h3333_0003;
      m_data  = 32'hDEAD_BEEF;
      rf_data = 32'hCAFE_F00D;
      // REG_WRITE | MEM_READ | ALU_SRC | ALU_OP=6  -> 0x0623
      ctrl = 16'((1 << CTRL_REG_WRITE) | (1 << CTRL_MEM_READ) |
                 (1 << CTRL_ALU_SRC) | (6 << CTRL_ALU_OP));

      // Reset state
      tick(2);
      check("rst_cpu_en", 32'(cpu_en), 32'h0);
      check("rst_addr",   32'(m_rf_addr), 32'h0);
      check("rst_disp",   disp, 32'h0);
      check("rst_led",    32'(led), 32'h0);
      rst = 1'b1;

      // Single step with the button held 50 cycles: one enable, none on release
      e = cyc;
      step = 1'b1;
      en_q.push_back(e + LAT);
      tick(50);
      step = 1'b0;
      tick(15);

      // Address wrap: 0x00 -dec-> 0xFF -inc-> 0x00
      e = cyc;
      dec = 1'b1;
      expect_obs("addr_before_dec", e + LAT - 1, OBS_ADDR, 32'h00);
      expect_obs("addr_wrap_down",  e + LAT,     OBS_ADDR, 32'hFF);
      expect_obs("addr_dec_once",   e + LAT + 5, OBS_ADDR, 32'hFF);
      tick(10);
      dec = 1'b0;
      tick(10);
      e = cyc;
      inc = 1'b1;
      expect_obs("addr_wrap_up", e + LAT, OBS_ADDR, 32'h00);
      tick(10);
      inc = 1'b0;
      tick(10);

      // Bring address to 0x05, then press inc and dec together
      repeat (5) press_inc();
      e = cyc;
      inc = 1'b1;
      dec = 1'b1;
      expect_obs("led_shows_addr",    e + 2,       OBS_LED,  32'h0005);
      expect_obs("addr_inc_dec_same", e + LAT,     OBS_ADDR, 32'h05);
      expect_obs("addr_inc_dec_hold", e + LAT + 3, OBS_ADDR, 32'h05);
      tick(10);
      inc = 1'b0;
      dec = 1'b0;
      tick(10);

      // Display / LED select table (address is 0x05, m_rf=1)
      sel_tab  = '{SEL_MRF, SEL_PC, SEL_NPC, SEL_IR, SEL_ID_EX, SEL_EX_MEM, SEL_MEM_WB, SEL_ADDR};
      disp_tab = '{32'hDEAD_BEEF, 32'h0040_0010, 32'h0040_0014, 32'h8C22_0004,
                   32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h0000_0005};
      led_tab  = '{16'h0005, 16'h0623, 16'h0623, 16'h0623,
                   16'h0623, 16'h0623, 16'h0623, 16'h0623};
      for (int s = 0; s < 8; s++) begin
         sel = sel_tab[s];
         expect_obs($sformatf("disp_sel%0d", s), cyc + 1, OBS_DISP, disp_tab[s]);
         expect_obs($sformatf("led_sel%0d", s),  cyc + 1, OBS_LED,  32'(led_tab[s]));
         tick(1);
      end
      sel  = SEL_MRF;
      m_rf = 1'b0;
      expect_obs("disp_rf_data", cyc + 1, OBS_DISP, 32'hCAFE_F00D);
      tick(3);
      m_rf = 1'b1;

      // Continuous run; step presses during RUN have no effect
      e = cyc;
      succ = 1'b1;
      for (int k = 1; k <= 20; k++) en_q.push_back(e + k);
      tick(2);
      step = 1'b1;
      tick(3);
      sel = SEL_IR;
      ir  = 32'h0123_4567;
      // MEM_WRITE | BRANCH | JUMP -> 0x001C
      ctrl = 16'((1 << CTRL_MEM_WRITE) | (1 << CTRL_BRANCH) | (1 << CTRL_JUMP));
      expect_obs("disp_ir_in_run", cyc + 1, OBS_DISP, 32'h0123_4567);
      expect_obs("led_ctrl_in_run", cyc + 1, OBS_LED, 32'h001C);
      tick(5);
      step = 1'b0;
      tick(10);
      succ = 1'b0;
      tick(12);

      // Reset asserted while the step enable is high
      e = cyc;
      step = 1'b1;
      tick(LAT);
      check("step_en_before_rst", 32'(cpu_en), 32'h1);
      #1;
      rst = 1'b0;
      #1;
      check("rst_async_cpu_en", 32'(cpu_en), 32'h0);
      check("rst_async_addr",   32'(m_rf_addr), 32'h0);
      check("rst_async_disp",   disp, 32'h0);
      tick(2);
      rst = 1'b1;
      // Button still held: counts as one new press once debounced
      f = cyc;
      en_q.push_back(f + LAT);
      tick(20);
      step = 1'b0;
      tick(15);

      check("scoreboard_drained", 32'(obs_q.size() + en_q.size()), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "timeout");
   end

endmodule
